// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Address map and event-index definitions for the
//               performance-counter CSR bank.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

   // Machine-mode counter block and its fixed slots
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
   // Upper 32 bits of any counter sit this far above the lower half
   localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
   // Read-only user-mode shadow block
   localparam logic [11:0] CSR_USER_BASE     = 12'hC00;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

   // Mask selecting the block bits of a counter address: bit 7 (high half)
   // and bits 4:0 (counter index) are don't-care, bits 6:5 must be zero.
   localparam logic [11:0] CSR_BLOCK_MASK    = 12'hF60;

   // Bit position of each event strobe on hpm_event_i
   typedef enum logic [2:0] {
      EV_LOAD_STALL   = 3'd0,
      EV_BR_MISPRED   = 3'd1,
      EV_BR_FLUSH     = 3'd2,
      EV_IC_MISS      = 3'd3,
      EV_IC_STALL     = 3'd4,
      EV_LDST_RETIRE  = 3'd5
   } hpm_event_e;

endpackage : perf_pkg
`default_nettype wire

// File: rtl/perf_counter64.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter64
// Description : One 64-bit wrapping event counter with independently
//               writable 32-bit halves. A write to either half wins over
//               the increment for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter64 (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        inc_i,
   input  logic        inhibit_i,
   input  logic        we_lo_i,
   input  logic        we_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] value_o
);

   logic [63:0] value_q;
   logic [63:0] value_d;

   // Next value: half-write has priority, otherwise count when enabled
   always_comb begin
      value_d = value_q;
      if (we_lo_i) begin
         value_d = {value_q[63:32], wdata_i};
      end else if (we_hi_i) begin
         value_d = {wdata_i, value_q[31:0]};
      end else if (inc_i && !inhibit_i) begin
         value_d = value_q + 64'd1;
      end
   end

   // Counter register with asynchronous clear
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         value_q <= 64'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;

endmodule : perf_counter64
`default_nettype wire

// File: rtl/perf_counter_csr.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_csr
// Description : Performance-counter bank (mcycle, minstret, mhpmcounterN,
//               user shadows, mcountinhibit) behind a CSR read/write port
//               with one-cycle registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_csr
   import perf_pkg::*;
#(
   parameter int NUM_HPM = 6
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               retire_i,
   input  logic [NUM_HPM-1:0] hpm_event_i,
   input  logic [11:0]        csr_addr_i,
   input  logic               csr_re_i,
   input  logic               csr_we_i,
   input  logic [31:0]        csr_wdata_i,
   output logic [31:0]        csr_rdata_o,
   output logic               csr_valid_o,
   output logic               csr_illegal_o
);

   // Counter slots: 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k)
   localparam int C_NUM_CNT = 2 + NUM_HPM;
   // Writable mcountinhibit bits: 0, 2 and 3..(2+NUM_HPM)
   localparam logic [63:0] C_INH_MASK64 =
      ((64'd1 << (3 + NUM_HPM)) - 64'd1) & ~64'd2;
   localparam logic [31:0] C_INH_MASK = C_INH_MASK64[31:0];

   logic [31:0] inh_q, inh_d;
   logic [31:0] rdata_q, rdata_d;
   logic        valid_q, valid_d;
   logic        illegal_q, illegal_d;

   logic [4:0]  w_idx;
   logic [4:0]  w_slot;
   logic        w_is_m, w_is_u, w_is_hi, w_is_inh;
   logic        w_idx_ok, w_cnt_hit, w_mapped, w_illegal, w_wr_ok;
   logic [63:0] w_cnt_val [C_NUM_CNT];
   logic [63:0] w_rd_val;
   logic [31:0] w_rd_word;

   // Address decode
   assign w_idx     = csr_addr_i[4:0];
   assign w_is_hi   = csr_addr_i[7];
   assign w_is_m    = (csr_addr_i & CSR_BLOCK_MASK) == CSR_MCYCLE;
   assign w_is_u    = (csr_addr_i & CSR_BLOCK_MASK) == CSR_USER_BASE;
   assign w_is_inh  = (csr_addr_i == CSR_MCOUNTINHIBIT);
   // Mapped counter indices: 0 (mcycle), 2 (minstret), 3..(2+NUM_HPM)
   assign w_idx_ok  = (w_idx == CSR_MCYCLE[4:0]) ||
                      (w_idx == CSR_MINSTRET[4:0]) ||
                      ((w_idx >= CSR_MHPM_BASE[4:0]) &&
                       ({27'd0, w_idx} < 32'(3 + NUM_HPM)));
   assign w_cnt_hit = (w_is_m || w_is_u) && w_idx_ok;
   assign w_mapped  = w_cnt_hit || w_is_inh;
   // Shadows are read-only; any write to that block is rejected
   assign w_illegal = (csr_re_i || csr_we_i) &&
                      (!w_mapped || (csr_we_i && w_is_u));
   assign w_wr_ok   = csr_we_i && !w_illegal;
   assign w_slot    = (w_idx == 5'd0) ? 5'd0 :
                      (w_idx == 5'd2) ? 5'd1 : (w_idx - 5'd1);

   // Counter instances with their increment sources and inhibit bits
   for (genvar s = 0; s < C_NUM_CNT; s++) begin : g_cnt
      localparam int C_INH_BIT = (s == 0) ? 0 : (s + 1);
      logic w_inc;
      logic w_hit;

      if (s == 0) begin : g_mcycle
         assign w_inc = 1'b1;
      end else if (s == 1) begin : g_minstret
         assign w_inc = retire_i;
      end else begin : g_hpm
         assign w_inc = hpm_event_i[s-2];
      end

      assign w_hit = w_wr_ok && w_cnt_hit && (w_slot == 5'(s));

      perf_counter64 u_cnt (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .inc_i     (w_inc),
         .inhibit_i (inh_q[C_INH_BIT]),
         .we_lo_i   (w_hit && !w_is_hi),
         .we_hi_i   (w_hit && w_is_hi),
         .wdata_i   (csr_wdata_i),
         .value_o   (w_cnt_val[s])
      );
   end

   // Read mux and next-state for the response and inhibit registers
   always_comb begin
      w_rd_val = 64'd0;
      for (int s = 0; s < C_NUM_CNT; s++) begin
         if (w_slot == 5'(s)) begin
            w_rd_val = w_cnt_val[s];
         end
      end
      w_rd_word = w_is_inh ? inh_q :
                  (w_is_hi ? w_rd_val[63:32] : w_rd_val[31:0]);

      rdata_d   = (csr_re_i && !w_illegal) ? w_rd_word : 32'd0;
      valid_d   = csr_re_i;
      illegal_d = w_illegal;
      inh_d     = (w_wr_ok && w_is_inh) ? (csr_wdata_i & C_INH_MASK) : inh_q;
   end

   // Registered CSR response and mcountinhibit, cleared asynchronously
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         inh_q     <= 32'd0;
         rdata_q   <= 32'd0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         inh_q     <= inh_d;
         rdata_q   <= rdata_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   assign csr_rdata_o   = rdata_q;
   assign csr_valid_o   = valid_q;
   assign csr_illegal_o = illegal_q;

endmodule : perf_counter_csr
`default_nettype wire

// File: tb/tb_perf_counter_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_counter_csr
// Description : Directed self-checking bench for perf_counter_csr: hand
//               sequences for timing corner cases plus a vector table of
//               CSR accesses with counters frozen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_csr;
   import perf_pkg::*;

   localparam int NUM_HPM = 6;

   logic               clk;
   logic               reset;
   logic               retire;
   logic [NUM_HPM-1:0] hpm_event;
   logic [11:0]        csr_addr;
   logic               csr_re;
   logic               csr_we;
   logic [31:0]        csr_wdata;
   logic [31:0]        csr_rdata;
   logic               csr_valid;
   logic               csr_illegal;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic        we;
      logic        re;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_valid;
      logic        exp_ill;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   perf_counter_csr #(.NUM_HPM(NUM_HPM)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .retire_i      (retire),
      .hpm_event_i   (hpm_event),
      .csr_addr_i    (csr_addr),
      .csr_re_i      (csr_re),
      .csr_we_i      (csr_we),
      .csr_wdata_i   (csr_wdata),
      .csr_rdata_o   (csr_rdata),
      .csr_valid_o   (csr_valid),
      .csr_illegal_o (csr_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Drive one request for one cycle (starting at a falling edge); outputs
   // are sampled by the caller at the following falling edge.
   task automatic acc(input logic we, input logic re, input logic [11:0] addr,
                      input logic [31:0] wdata);
      csr_we    = we;
      csr_re    = re;
      csr_addr  = addr;
      csr_wdata = wdata;
      @(negedge clk);
      csr_we    = 1'b0;
      csr_re    = 1'b0;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] wdata);
      acc(1'b1, 1'b0, addr, wdata);
   endtask

   task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
      acc(1'b0, 1'b1, addr, 32'd0);
      chk({name, "_valid"}, {31'd0, csr_valid}, 32'd1);
      chk({name, "_ill"}, {31'd0, csr_illegal}, 32'd0);
      chk(name, csr_rdata, exp);
   endtask

   function automatic vec_t mk(input logic we, input logic re, input logic [11:0] a,
                               input logic [31:0] wd, input logic [31:0] er,
                               input logic ev, input logic ei);
      vec_t v;
      v.we = we; v.re = re; v.addr = a; v.wdata = wd;
      v.exp_rdata = er; v.exp_valid = ev; v.exp_ill = ei;
      return v;
   endfunction

   initial begin
      // Table run with every counter inhibited so values are static
      vecs[0]  = mk(1, 0, 12'h320, 32'hFFFF_FFFF, 32'h0,         0, 0);
      vecs[1]  = mk(0, 1, 12'h320, 32'h0,         32'h0000_01FD, 1, 0);
      vecs[2]  = mk(1, 0, 12'hB00, 32'h1234_5678, 32'h0,         0, 0);
      vecs[3]  = mk(0, 1, 12'hB00, 32'h0,         32'h1234_5678, 1, 0);
      vecs[4]  = mk(0, 1, 12'hC00, 32'h0,         32'h1234_5678, 1, 0);
      vecs[5]  = mk(1, 0, 12'hB80, 32'hCAFE_BABE, 32'h0,         0, 0);
      vecs[6]  = mk(0, 1, 12'hC80, 32'h0,         32'hCAFE_BABE, 1, 0);
      vecs[7]  = mk(0, 1, 12'hB00, 32'h0,         32'h1234_5678, 1, 0);
      vecs[8]  = mk(1, 0, 12'hC03, 32'h1,         32'h0,         0, 1);
      vecs[9]  = mk(0, 1, 12'hB01, 32'h0,         32'h0,         1, 1);
      vecs[10] = mk(0, 1, 12'hB08, 32'h0,         32'h0,         1, 0);
      vecs[11] = mk(0, 1, 12'hB09, 32'h0,         32'h0,         1, 1);
      vecs[12] = mk(1, 0, 12'hB88, 32'hDEAD_BEEF, 32'h0,         0, 0);
      vecs[13] = mk(0, 1, 12'hC88, 32'h0,         32'hDEAD_BEEF, 1, 0);
      vecs[14] = mk(0, 1, 12'h321, 32'h0,         32'h0,         1, 1);
      vecs[15] = mk(0, 1, 12'hB20, 32'h0,         32'h0,         1, 1);
      vecs[16] = mk(1, 0, 12'hB02, 32'h0000_0055, 32'h0,         0, 0);
      vecs[17] = mk(0, 1, 12'hC02, 32'h0,         32'h0000_0055, 1, 0);
      vecs[18] = mk(0, 1, 12'h000, 32'h0,         32'h0,         1, 1);
      vecs[19] = mk(1, 1, 12'hB00, 32'h0000_0099, 32'h1234_5678, 1, 0);

      reset = 1'b1; retire = 1'b0; hpm_event = '0;
      csr_addr = 12'h0; csr_re = 1'b0; csr_we = 1'b0; csr_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_rdata", csr_rdata, 32'd0);
      chk("rst_valid", {31'd0, csr_valid}, 32'd0);
      chk("rst_ill", {31'd0, csr_illegal}, 32'd0);
      reset = 1'b0;

      // Ten idle cycles after reset, then mcycle = 10, minstret = 0
      repeat (10) @(negedge clk);
      rd_chk("mcycle_after10", 12'hB00, 32'd10);
      rd_chk("minstret_zero", 12'hB02, 32'd0);

      // Low-to-high carry
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      @(negedge clk);
      rd_chk("carry_lo", 12'hB00, 32'h0);
      rd_chk("carry_hi", 12'hB80, 32'h1);

      // Write beats a simultaneous event increment
      hpm_event[EV_LOAD_STALL] = 1'b1;
      wr(12'hB03, 32'h0000_1000);
      hpm_event[EV_LOAD_STALL] = 1'b0;
      rd_chk("hpm3_write_wins", 12'hB03, 32'h0000_1000);

      // mcountinhibit = 0x5 freezes mcycle/minstret, hpm3 keeps counting
      wr(12'hB00, 32'd100);
      wr(12'hB80, 32'd0);
      wr(12'hB02, 32'd200);
      wr(12'hB03, 32'd0);
      wr(12'h320, 32'h5);
      retire = 1'b1;
      hpm_event[EV_LOAD_STALL] = 1'b1;
      repeat (8) @(negedge clk);
      retire = 1'b0;
      hpm_event[EV_LOAD_STALL] = 1'b0;
      rd_chk("inh_mcycle", 12'hB00, 32'd103);
      rd_chk("inh_minstret", 12'hB02, 32'd200);
      rd_chk("inh_hpm3", 12'hB03, 32'd8);
      rd_chk("inh_readback", 12'h320, 32'h5);
      wr(12'h320, 32'h2);
      rd_chk("inh_bit1_zero", 12'h320, 32'h0);

      // Shadow write is illegal and leaves mcycle alone
      wr(12'h320, 32'h1);
      wr(12'hB00, 32'd500);
      wr(12'hC00, 32'h77);
      chk("shadow_wr_ill", {31'd0, csr_illegal}, 32'd1);
      chk("shadow_wr_valid", {31'd0, csr_valid}, 32'd0);
      rd_chk("shadow_mcycle", 12'hB00, 32'd500);
      acc(1'b0, 1'b1, 12'hB1F, 32'd0);
      chk("b1f_ill", {31'd0, csr_illegal}, 32'd1);
      chk("b1f_valid", {31'd0, csr_valid}, 32'd1);
      chk("b1f_rdata", csr_rdata, 32'd0);

      // Reset while a read is in flight
      wr(12'h320, 32'h0);
      csr_re = 1'b1; csr_addr = 12'hB03;
      @(negedge clk);
      chk("pre_rst_rdata", csr_rdata, 32'd8);
      csr_addr = 12'hB02;
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, csr_valid}, 32'd0);
      chk("midrst_rdata", csr_rdata, 32'd0);
      @(negedge clk);
      csr_re = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("postrst_valid", {31'd0, csr_valid}, 32'd0);
      rd_chk("postrst_mcycle", 12'hB00, 32'd1);
      rd_chk("postrst_minstret", 12'hB02, 32'd0);
      rd_chk("postrst_hpm3", 12'hB03, 32'd0);
      rd_chk("postrst_mcycle_hi", 12'hB80, 32'd0);
      rd_chk("postrst_inh", 12'h320, 32'd0);

      // Vector table
      for (int i = 0; i < NVEC; i++) begin
         acc(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_valid", i), {31'd0, csr_valid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_ill", i), {31'd0, csr_illegal}, {31'd0, vecs[i].exp_ill});
         if (vecs[i].re) chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      end
      // Read-and-write in the same cycle: the write committed
      rd_chk("rw_commit", 12'hB00, 32'h0000_0099);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_perf_counter_csr
`default_nettype wire

// File: doc/perf_counter_csr.md
# perf_counter_csr

Hardware performance-counter bank exposing pipeline event counts to software through the CSR interface. Implements RISC-V `mcycle`, `minstret`, `mhpmcounter3..` with their high halves, user-mode read-only shadows, and `mcountinhibit`. Event strobes come from the writeback, hazard, branch and I-cache logic. Reads and writes arrive from the CSR unit in the execute stage.

## Interface
- `NUM_HPM`, 6: number of programmable counters, mapped to `mhpmcounter3 .. mhpmcounter(2+NUM_HPM)`; legal range 1..29.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  reset; asynchronous, active-high; clears all state.
- `retire_i`  in  1  one instruction retired this cycle (valid, non-stalled, non-NOP at writeback).
- `hpm_event_i`  in  NUM_HPM  per-cycle event strobes. Bit k increments `mhpmcounter(3+k)`. Fixed wiring:
  - 0: load stall
  - 1: branch mispredict
  - 2: branch-flush stall cycle
  - 3: I-cache miss
  - 4: I-cache stall cycle
  - 5: load/store retired
- `csr_addr_i`  in  12  CSR address.
- `csr_re_i`  in  1  read request.
- `csr_we_i`  in  1  write request.
- `csr_wdata_i`  in  32  write data.
- `csr_rdata_o`  out  32  read data, registered; 0 at reset.
- `csr_valid_o`  out  1  `csr_rdata_o` valid; 0 at reset.
- `csr_illegal_o`  out  1  access to an unmapped or read-only address, registered; 0 at reset.

## Operation
- Address map. Constants live in the package.
  - `mcycle` 0xB00, `minstret` 0xB02, `mhpmcounterN` 0xB00+N.
  - High halves at +0x80.
  - Shadows `cycle`, `instret` and `hpmcounterN` at 0xC00+ and 0xC80+; read-only.
  - `mcountinhibit` 0x320.
- Counters: 64-bit, unsigned, wrap from 2^64-1 to 0. Carry from the low half into the high half happens in the same cycle.
- `mcycle` increments every cycle unless `mcountinhibit[0]` is set.
- `minstret` increments when `retire_i` is high and `mcountinhibit[2]` is clear.
- `hpm[k]` increments when `hpm_event_i[k]` is high and `mcountinhibit[3+k]` is clear.
- `mcountinhibit`:
  - Bits 0, 2 and 3..(2+NUM_HPM) are writable.
  - All other bits, including bit 1, read 0.
  - Reset value is 0.
- Write to a counter half replaces those 32 bits only. The written counter does not increment in that cycle, so the write wins. The other half holds, with no carry.
- Read returns the addressed 32-bit half.
- Illegal access, with `csr_illegal_o` = 1, `csr_rdata_o` = 0 and no state change:
  - a write to a 0xC00/0xC80 shadow;
  - any access to an unmapped address;
  - an HPM index at or above 3+NUM_HPM.
- `csr_re_i` and `csr_we_i` both high to the same address: the read returns the pre-write value and the write commits.

## Timing
- Read latency is 1 cycle. `csr_valid_o` pulses high in the cycle after `csr_re_i` and holds for one cycle per request. Back-to-back reads are allowed every cycle.
- Read data is the counter value sampled at the edge that ends the request cycle. It excludes that cycle's increment and write.
- Writes and increments take effect at the edge ending the request cycle. A read of the same address in the next cycle sees the written value with no increment added.
- `mcountinhibit` write: inhibition applies from the following cycle. The increment in the write cycle still uses the old mask.
- Reset mid-operation: all counters, the mask and the outputs clear immediately, asynchronously. Any in-flight read is dropped: `csr_valid_o` is 0 at the first edge after reset deasserts.
- No backpressure. The CSR unit is assumed never to stall a pending read response.

## Structure
- `perf_pkg` holds:
  - the CSR address constants (`CSR_MCYCLE`, `CSR_MINSTRET`, `CSR_MHPM_BASE`, `CSR_HI_OFFSET`, `CSR_USER_BASE`, `CSR_MCOUNTINHIBIT`);
  - the `hpm_event_e` enum of event indices.
- Sub-module `perf_counter64`: one 64-bit counter.
  - Inputs: `inc`, `inhibit`, `we_lo`, `we_hi`, `wdata`.
  - Output: `value`.
  - It is instantiated 2+NUM_HPM times.
- The top level contains address decode, the read mux register and the `mcountinhibit` register.

## Test plan
- Reset, then 10 idle cycles, then read 0xB00 -> `csr_valid_o` the next cycle, `csr_rdata_o` = 10 (±0 with fixed alignment); `minstret` reads 0.
- Write 0xB00 = 0xFFFFFFFF and 0xB80 = 0, then wait 1 cycle -> low reads 0x00000000 or later and high reads 0x00000001 (carry).
- Write 0xB03 with `hpm_event_i[0]` high in the same cycle -> next read of 0xB03 returns exactly the written value.
- Write `mcountinhibit` = 0x5, hold `retire_i` high for 8 cycles -> `mcycle` and `minstret` frozen; `hpm3` still counts its strobes; bit 1 reads 0.
- Write 0xC00 -> `csr_illegal_o` = 1, `mcycle` unchanged. Read 0xB1F with NUM_HPM = 6 -> illegal, rdata 0.
- Assert `reset_i` mid-read with counters nonzero -> all counters read 0 and no stale `csr_valid_o`.
